ddr3_mc_rw_arb: RTL

- Multi-channel successor to the single-channel DDR3 read/write request controller.
- Sits between N per-channel write/read FIFO pairs and the single AXI master user port, on the DDR3 IP ui_clk domain.
- Arbitrates write and read bursts round-robin across channels and keeps an independent wrapping address pointer per channel and direction.
- Adds per-channel enables, a completion watchdog and error reporting.

---
 rtl/ddr3_mc_rw_arb.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_mc_rw_arb.sv
// Multi-channel DDR3 read/write burst arbiter: round-robin grants across channel FIFO pairs,
// per-channel wrapping address pointers, completion watchdog with sticky per-channel errors.
module ddr3_mc_rw_arb #(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 28,
   parameter int LEN_W       = 10,
   parameter int CNT_W       = 11,
   parameter int RFIFO_DEPTH = 1024,
   parameter int TIMEOUT     = 4095,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ddr3_init_done,
   input  logic [NUM_CH-1:0]        ch_wr_en,
   input  logic [NUM_CH-1:0]        ch_rd_en,
   input  logic [NUM_CH*ADDR_W-1:0] addr_wd_min,
   input  logic [NUM_CH*ADDR_W-1:0] addr_wd_max,
   input  logic [NUM_CH*ADDR_W-1:0] addr_rd_min,
   input  logic [NUM_CH*ADDR_W-1:0] addr_rd_max,
   input  logic [NUM_CH*LEN_W-1:0]  wd_burst_len,
   input  logic [NUM_CH*LEN_W-1:0]  rd_burst_len,
   input  logic [NUM_CH*CNT_W-1:0]  wfifo_rcount,
   input  logic [NUM_CH*CNT_W-1:0]  rfifo_wcount,
   output logic                     wd_req,
   output logic                     rd_req,
   output logic [ADDR_W-1:0]        wd_addr,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [LEN_W-1:0]         wd_len,
   output logic [LEN_W-1:0]         rd_len,
   output logic [CH_W-1:0]          wd_ch,
   output logic [CH_W-1:0]          rd_ch,
   input  logic                     wd_finish,
   input  logic                     rd_finish,
   output logic                     busy,
   output logic [NUM_CH-1:0]        timeout_err,
   output logic [2:0]               fsm_state
);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARB     = 3'd1,
      S_WR_REQ  = 3'd2,
      S_WR_WAIT = 3'd3,
      S_RD_REQ  = 3'd4,
      S_RD_WAIT = 3'd5
   } state_t;

   state_t              state, state_nxt;
   logic                dir_pri;
   logic [CH_W-1:0]     rr_w, rr_r, w_sel, r_sel;
   logic [ADDR_W-1:0]   wr_ptr [NUM_CH];
   logic [ADDR_W-1:0]   rd_ptr [NUM_CH];
   logic [NUM_CH-1:0]   wr_vld, rd_vld, w_elig, r_elig;
   logic                w_any, r_any, grant_wr, grant_rd;
   logic                wr_done, rd_done, wr_tmo, rd_tmo, wdog_hit;
   logic [WD_W-1:0]     wdog_cnt;
   logic [ADDR_W-1:0]   wr_next, rd_next;

   function automatic logic [CH_W-1:0] nxt_ch(input logic [CH_W-1:0] ch);
      return (int'(ch) == NUM_CH - 1) ? '0 : ch + 1'b1;
   endfunction

   // Extra bit keeps ptr+2*len from wrapping when the window ends near 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] ptr,
                                                 input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] lo,
                                                 input logic [ADDR_W-1:0] hi);
      logic [ADDR_W:0] sum;
      sum = {1'b0, ptr} + (ADDR_W+1)'(len);
      if (sum + (ADDR_W+1)'(len) > {1'b0, hi}) return lo;
      return sum[ADDR_W-1:0];
   endfunction

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_elig[c] = ch_wr_en[c] && wr_vld[c] && (wd_burst_len[c*LEN_W +: LEN_W] != '0) &&
                     ({1'b0, wfifo_rcount[c*CNT_W +: CNT_W]} >=
                      (CNT_W+1)'(wd_burst_len[c*LEN_W +: LEN_W]));
         r_elig[c] = ch_rd_en[c] && rd_vld[c] && (rd_burst_len[c*LEN_W +: LEN_W] != '0) &&
                     (({1'b0, rfifo_wcount[c*CNT_W +: CNT_W]} +
                       (CNT_W+1)'(rd_burst_len[c*LEN_W +: LEN_W])) <= (CNT_W+1)'(RFIFO_DEPTH));
      end
   end

   // Scan offsets from high to low so the eligible channel closest to rr_ptr is kept last.
   always_comb begin
      int idx;
      idx   = 0;
      w_any = 1'b0;
      w_sel = '0;
      r_any = 1'b0;
      r_sel = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = int'(rr_w) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (w_elig[idx]) begin
            w_any = 1'b1;
            w_sel = CH_W'(idx);
         end
         idx = int'(rr_r) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (r_elig[idx]) begin
            r_any = 1'b1;
            r_sel = CH_W'(idx);
         end
      end
   end

   assign wdog_hit = (wdog_cnt == WD_W'(TIMEOUT - 1));
   assign wr_next  = advance(wr_ptr[wd_ch], wd_len, addr_wd_min[wd_ch*ADDR_W +: ADDR_W],
                             addr_wd_max[wd_ch*ADDR_W +: ADDR_W]);
   assign rd_next  = advance(rd_ptr[rd_ch], rd_len, addr_rd_min[rd_ch*ADDR_W +: ADDR_W],
                             addr_rd_max[rd_ch*ADDR_W +: ADDR_W]);

   // Handshake: *_req is a one-cycle start pulse with addr/len/ch already stable; the master
   // answers with a one-cycle *_finish, honoured only in the matching WAIT state.
   always_comb begin
      state_nxt = state;
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      wr_done   = 1'b0;
      rd_done   = 1'b0;
      wr_tmo    = 1'b0;
      rd_tmo    = 1'b0;
      case (state)
         S_IDLE:    if (ddr3_init_done) state_nxt = S_ARB;
         S_ARB: begin
            if (!ddr3_init_done) begin
               state_nxt = S_IDLE;
            end else if (w_any && (!dir_pri || !r_any)) begin
               grant_wr  = 1'b1;
               state_nxt = S_WR_REQ;
            end else if (r_any) begin
               grant_rd  = 1'b1;
               state_nxt = S_RD_REQ;
            end
         end
         S_WR_REQ:  state_nxt = S_WR_WAIT;
         S_WR_WAIT: begin
            if (wd_finish) begin
               wr_done   = 1'b1;
               state_nxt = S_IDLE;
            end else if (wdog_hit) begin
               wr_tmo    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_RD_REQ:  state_nxt = S_RD_WAIT;
         S_RD_WAIT: begin
            if (rd_finish) begin
               rd_done   = 1'b1;
               state_nxt = S_IDLE;
            end else if (wdog_hit) begin
               rd_tmo    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   assign busy      = (state != S_IDLE);
   assign wd_req    = (state == S_WR_REQ);
   assign rd_req    = (state == S_RD_REQ);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_addr     <= '0;
         wd_len      <= '0;
         wd_ch       <= '0;
         rd_addr     <= '0;
         rd_len      <= '0;
         rd_ch       <= '0;
         rr_w        <= '0;
         rr_r        <= '0;
         dir_pri     <= 1'b0;
         timeout_err <= '0;
         wdog_cnt    <= '0;
      end else begin
         if (grant_wr) begin
            wd_addr <= wr_ptr[w_sel];
            wd_len  <= wd_burst_len[w_sel*LEN_W +: LEN_W];
            wd_ch   <= w_sel;
         end
         if (grant_rd) begin
            rd_addr <= rd_ptr[r_sel];
            rd_len  <= rd_burst_len[r_sel*LEN_W +: LEN_W];
            rd_ch   <= r_sel;
         end
         if (wr_done || wr_tmo) rr_w <= nxt_ch(wd_ch);
         if (rd_done || rd_tmo) rr_r <= nxt_ch(rd_ch);
         if (wr_done) dir_pri <= 1'b1;
         if (rd_done) dir_pri <= 1'b0;
         if (wr_tmo)  timeout_err[wd_ch] <= 1'b1;
         if (rd_tmo)  timeout_err[rd_ch] <= 1'b1;
         if (state == S_WR_REQ || state == S_RD_REQ)
            wdog_cnt <= '0;
         else if (state == S_WR_WAIT || state == S_RD_WAIT)
            wdog_cnt <= wdog_cnt + 1'b1;
      end
   end

   // A dropped enable invalidates the pointer so re-enabling restarts at the window minimum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_vld <= '0;
         rd_vld <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (!ch_wr_en[c]) begin
               wr_vld[c] <= 1'b0;
            end else if (!wr_vld[c]) begin
               if (ddr3_init_done) begin
                  wr_ptr[c] <= addr_wd_min[c*ADDR_W +: ADDR_W];
                  wr_vld[c] <= 1'b1;
               end
            end else if (wr_done && (wd_ch == CH_W'(c))) begin
               wr_ptr[c] <= wr_next;
            end
            if (!ch_rd_en[c]) begin
               rd_vld[c] <= 1'b0;
            end else if (!rd_vld[c]) begin
               if (ddr3_init_done) begin
                  rd_ptr[c] <= addr_rd_min[c*ADDR_W +: ADDR_W];
                  rd_vld[c] <= 1'b1;
               end
            end else if (rd_done && (rd_ch == CH_W'(c))) begin
               rd_ptr[c] <= rd_next;
            end
         end
      end
   end

endmodule
